instr_loader: RTL

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/mips_pkg.sv | 23 ++
 rtl/byte_packer.sv | 23 ++
 rtl/instr_loader.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants and loader state encoding; no logic, no latency.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] OP_HALT    = 6'b111111;

  localparam logic [31:0] HALT_WORD_DEF = {OP_HALT, 26'd0};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERROR = 3'd5
  } ld_state_t;

endpackage

// File: rtl/byte_packer.sv
// MSB-first 4-byte shift register with 2-bit byte index; word updates on the shift edge.
// Never stalls: the caller decides when a byte is accepted.
module byte_packer (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic [1:0]  o_idx
);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      o_word <= 32'd0;
      o_idx  <= 2'd0;
    end else if (i_shift) begin
      o_word <= {o_word[23:0], i_byte};
      o_idx  <= o_idx + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Serial-byte to instruction-memory loader; word written 1 cycle after its 4th byte, HALT_WORD ends a session.
// Backpressure: o_rx_ready low outside byte-accepting states. Trailing checksum byte with INSTR_LOADER_CHECKSUM_EN.
module instr_loader
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W:0]   o_word_count
);

  ld_state_t         state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   word_count;
  logic [31:0]       pk_word;
  logic [1:0]        pk_idx;
  logic              xfer, start_ok, addr_last, word_is_halt;

  assign xfer         = i_rx_valid && o_rx_ready;
  assign start_ok     = i_start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
  assign addr_last    = (addr == {ADDR_W{1'b1}});
  assign word_is_halt = (pk_word == HALT_WORD);

  byte_packer u_packer (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clr   (start_ok),
    .i_shift (xfer && (state == ST_RECV)),
    .i_byte  (i_rx_data),
    .o_word  (pk_word),
    .o_idx   (pk_idx)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Address saturates at the top word so an overflow never aliases onto address 0.
  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok) begin
      addr       <= '0;
      word_count <= '0;
    end else if (state == ST_WRITE) begin
      word_count <= word_count + (ADDR_W+1)'(1);
      if (!word_is_halt && !addr_last) addr <= addr + ADDR_W'(1);
    end
  end

`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge i_clk) begin
    if (i_rst || start_ok)                csum <= 8'd0;
    else if (xfer && (state == ST_RECV)) csum <= csum ^ i_rx_data;
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (i_start) state_nxt = ST_RECV;
      ST_RECV:  if (xfer && (pk_idx == 2'd3)) state_nxt = ST_WRITE;
      ST_WRITE: begin
        if (word_is_halt) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          state_nxt = ST_CHECK;
`else
          state_nxt = ST_DONE;
`endif
        end else if (addr_last) begin
          state_nxt = ST_ERROR;
        end else begin
          state_nxt = ST_RECV;
        end
      end
      ST_CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        if (xfer) state_nxt = (i_rx_data == csum) ? ST_DONE : ST_ERROR;
`else
        state_nxt = ST_IDLE;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_rx_ready = 1'b0;
    o_mem_we   = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    o_err      = 1'b0;
    case (state)
      ST_RECV: begin
        o_rx_ready = 1'b1;
        o_busy     = 1'b1;
      end
      ST_WRITE: begin
        o_mem_we = 1'b1;
        o_busy   = 1'b1;
      end
      ST_CHECK: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        o_rx_ready = 1'b1;
`endif
        o_busy = 1'b1;
      end
      ST_DONE:  o_done = 1'b1;
      ST_ERROR: o_err  = 1'b1;
      default: ;
    endcase
  end

  assign o_mem_addr   = addr;
  assign o_mem_data   = pk_word;
  assign o_word_count = word_count;

endmodule
